// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-synchronous sprite motion for color_mapper.
// Applies the latest WASD/space direction command once per frame, steps the
// sprite centre and reflects it off the screen edges.
module sprite_motion_ctrl #(
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned X_CENTER = 320,
    parameter int unsigned Y_CENTER = 240,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SIZE     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       moving
);

    localparam int unsigned PW = 10;   // position width
    localparam int unsigned AW = 11;   // boundary arithmetic width

    localparam logic [AW-1:0] STEP_W = AW'(STEP);
    localparam logic [AW-1:0] REACH  = AW'(SIZE + STEP);
    localparam logic [AW-1:0] X_HI   = AW'(X_MAX);
    localparam logic [AW-1:0] Y_HI   = AW'(Y_MAX);
    localparam logic [AW-1:0] X_LO   = AW'(X_MIN + SIZE + STEP);
    localparam logic [AW-1:0] Y_LO   = AW'(Y_MIN + SIZE + STEP);

    // Direction state; DIR_NONE only ever appears in the pending-command register.
    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4,
        DIR_NONE  = 3'd7
    } dir_e;

    logic          s1_q, s2_q, s3_q, s3_d;
    logic [1:0]    init_q, init_d;
    dir_e          pend_q, pend_d;
    dir_e          dir_q, dir_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic          moving_q, moving_d;

    logic          tick;
    logic          init_done;
    logic          key_hit;
    dir_e          key_dir;
    dir_e          dir_sel;
    dir_e          dir_fin;
    logic [AW-1:0] x_ext, y_ext;

    assign tick      = s2_q & ~s3_q;
    assign init_done = (init_q == 2'd2);
    assign x_ext     = {1'b0, x_q};
    assign y_ext     = {1'b0, y_q};

    // Keycode decode to a direction command.
    always_comb begin
        key_hit = 1'b1;
        key_dir = DIR_NONE;
        case (keycode)
            8'h1A:   key_dir = DIR_UP;
            8'h16:   key_dir = DIR_DOWN;
            8'h04:   key_dir = DIR_LEFT;
            8'h07:   key_dir = DIR_RIGHT;
            8'h2C:   key_dir = DIR_STOP;
            default: key_hit = 1'b0;
        endcase
    end

    // Next-state: pending command, synchroniser fill, direction, bounce and step.
    always_comb begin
        pend_d   = pend_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        init_d   = init_done ? init_q : init_q + 2'd1;
        // Until s2 holds a real sample, s3 shadows s2's input so no edge is seen.
        s3_d     = init_done ? s2_q : s1_q;

        // A key on the tick edge survives into the next frame.
        if (key_hit) begin
            pend_d = key_dir;
        end else if (tick) begin
            pend_d = DIR_NONE;
        end

        dir_sel = (pend_q != DIR_NONE) ? pend_q : dir_q;
        dir_fin = dir_sel;
        case (dir_sel)
            DIR_RIGHT: if (x_ext + REACH > X_HI) dir_fin = DIR_LEFT;
            DIR_LEFT:  if (x_ext < X_LO)         dir_fin = DIR_RIGHT;
            DIR_DOWN:  if (y_ext + REACH > Y_HI) dir_fin = DIR_UP;
            DIR_UP:    if (y_ext < Y_LO)         dir_fin = DIR_DOWN;
            default:   dir_fin = dir_sel;
        endcase

        if (tick) begin
            dir_d = dir_fin;
            case (dir_fin)
                DIR_RIGHT: x_d = PW'(x_ext + STEP_W);
                DIR_LEFT:  x_d = PW'(x_ext - STEP_W);
                DIR_DOWN:  y_d = PW'(y_ext + STEP_W);
                DIR_UP:    y_d = PW'(y_ext - STEP_W);
                default:   x_d = x_q;
            endcase
        end

        moving_d = (dir_d != DIR_STOP);
    end

    // State register with asynchronous reset to the centred, stopped sprite.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            init_q   <= 2'd0;
            pend_q   <= DIR_NONE;
            dir_q    <= DIR_STOP;
            x_q      <= PW'(X_CENTER);
            y_q      <= PW'(Y_CENTER);
            moving_q <= 1'b0;
        end else begin
            s1_q     <= frame_clk;
            s2_q     <= s1_q;
            s3_q     <= s3_d;
            init_q   <= init_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            moving_q <= moving_d;
        end
    end

    assign BallX     = x_q;
    assign BallY     = y_q;
    assign Ball_size = PW'(SIZE);
    assign moving    = moving_q;

endmodule
